// File: rtl/trng_vn_collect.sv
// trng_vn_collect: samples an asynchronous ring-oscillator bit, decimates it by DIV,
// applies von Neumann debiasing and collects N unbiased bits per request.
// Optional macro TRNG_RCT_EN adds a repetition-count health test on the raw samples.
// Latency is at least 2*N*DIV cycles from request acceptance to result.
// Backpressure: the result is held in S_DONE until res_ready, and requests are refused while busy.
module trng_vn_collect #(
  parameter int unsigned N         = 128,
  parameter int unsigned DIV       = 4,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ent_bit,
  output logic [N-1:0] o_rnd_out,
  output logic         o_health_fail,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  output logic         o_req_busy,
  output logic         o_res_valid,
  input  logic         i_res_ready
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Out-of-range parameters are rejected at elaboration rather than producing odd widths.
  generate
    if (N < 2 || N > 256 || DIV < 2 || DIV > 255 || RCT_LIMIT < 2 || RCT_LIMIT > 255) begin : g_bad_param
      $error("trng_vn_collect: parameter out of range");
    end
  endgenerate

  state_t         r_state;
  logic           r_sync1;
  logic           r_sync2;
  logic [7:0]     r_div_cnt;
  logic [CW-1:0]  r_bit_cnt;
  logic           r_pair_full;
  logic           r_pair_first;
  logic [N-2:0]   r_word;

  logic           w_raw;
  logic           w_strobe;
  logic           w_emit;
  logic           w_last;
  logic [N-1:0]   w_next_word;

`ifdef TRNG_RCT_EN
  logic [7:0]     r_rct_cnt;
  logic           r_rct_prev;
  logic           r_health_fail;
  logic [7:0]     w_rct_next;
  logic           w_rct_trip;
`endif

  // Two-flop synchroniser for the asynchronous entropy input; free-running, never reset.
  always_ff @(posedge i_clk) begin
    r_sync1 <= i_ent_bit;
    r_sync2 <= r_sync1;
  end

  assign w_raw       = r_sync2;
  assign w_strobe    = (r_state == S_COLLECT) && (r_div_cnt == 8'(DIV - 1));
  // A completed pair emits only when its two bits differ; the emitted bit is the first one.
  assign w_emit      = r_pair_full && (r_pair_first != w_raw);
  assign w_next_word = {r_word, r_pair_first};
  assign w_last      = (r_bit_cnt == CW'(N - 1));

`ifdef TRNG_RCT_EN
  // Run length of identical raw samples, restarting at 1 on the first sample of a request.
  always_comb begin
    w_rct_next = 8'd1;
    if (r_rct_cnt != 8'd0 && w_raw == r_rct_prev) begin
      w_rct_next = r_rct_cnt + 8'd1;
    end
  end

  assign w_rct_trip    = (w_rct_next == 8'(RCT_LIMIT));
  assign o_health_fail = r_health_fail;
`else
  assign o_health_fail = 1'b0;
`endif

  // Control FSM: handshake, decimation, pairing, word assembly and result hand-off.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      o_req_ready  <= 1'b1;
      o_req_busy   <= 1'b0;
      o_res_valid  <= 1'b0;
      o_rnd_out    <= '0;
      r_div_cnt    <= 8'd0;
      r_bit_cnt    <= '0;
      r_pair_full  <= 1'b0;
      r_pair_first <= 1'b0;
      r_word       <= '0;
`ifdef TRNG_RCT_EN
      r_rct_cnt     <= 8'd0;
      r_rct_prev    <= 1'b0;
      r_health_fail <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            r_state     <= S_COLLECT;
            o_req_ready <= 1'b0;
            o_req_busy  <= 1'b1;
            r_div_cnt   <= 8'd0;
            r_bit_cnt   <= '0;
            r_pair_full <= 1'b0;
            r_word      <= '0;
`ifdef TRNG_RCT_EN
            r_rct_cnt     <= 8'd0;
            r_health_fail <= 1'b0;
`endif
          end
        end

        S_COLLECT: begin
          if (w_strobe) begin
            r_div_cnt <= 8'd0;
`ifdef TRNG_RCT_EN
            r_rct_cnt  <= w_rct_next;
            r_rct_prev <= w_raw;
            // A stuck source takes priority over any bit completing on the same strobe.
            if (w_rct_trip) begin
              o_rnd_out     <= '0;
              r_health_fail <= 1'b1;
              o_res_valid   <= 1'b1;
              o_req_busy    <= 1'b0;
              r_state       <= S_DONE;
            end else
`endif
            begin
              if (!r_pair_full) begin
                r_pair_first <= w_raw;
                r_pair_full  <= 1'b1;
              end else begin
                r_pair_full <= 1'b0;
                if (w_emit) begin
                  r_word    <= w_next_word[N-2:0];
                  r_bit_cnt <= r_bit_cnt + CW'(1);
                  if (w_last) begin
                    o_rnd_out   <= w_next_word;
                    o_res_valid <= 1'b1;
                    o_req_busy  <= 1'b0;
                    r_state     <= S_DONE;
                  end
                end
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        S_DONE: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_vn_collect.sv
// Bench for trng_vn_collect: drives ent_bit from per-cycle patterns or $urandom,
// records every driven bit, and predicts results from the sampled stream.
module tb_trng_vn_collect;

  localparam int N         = 128;
  localparam int DIV       = 4;
  localparam int RCT_LIMIT = 32;
  localparam int MASK      = 65535;

  logic         clk = 1'b0;
  logic         rst;
  logic         ent_bit;
  logic [N-1:0] rnd_out;
  logic         health_fail;
  logic         req_valid;
  logic         req_ready;
  logic         req_busy;
  logic         res_valid;
  logic         res_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int pmode = 0;
  bit v [0:MASK];

  always #5 clk = ~clk;

  trng_vn_collect #(.N(N), .DIV(DIV), .RCT_LIMIT(RCT_LIMIT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ent_bit     (ent_bit),
    .o_rnd_out     (rnd_out),
    .o_health_fail (health_fail),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .o_req_busy    (req_busy),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready)
  );

  // Source bit for the current cycle. Patterned modes are aligned so that strobe k
  // (edge base+k*DIV) sees pattern element k, allowing for the 2-flop synchroniser.
  function automatic bit src_bit();
    int j;
    int k;
    j = cyc - base + 3;
    k = (j <= 0) ? 0 : (j + DIV - 1) / DIV;
    case (pmode)
      1: return (k % 2) == 1;
      2: begin
        if (k == 0) return 1'b0;
        case ((k - 1) % 10)
          1, 2, 6, 7, 8: return 1'b1;
          default:       return 1'b0;
        endcase
      end
      3: return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Entropy driver: edge count and recorded bit driven just after each edge.
  initial begin : drv
    bit b;
    ent_bit = 1'b0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      b = src_bit();
      ent_bit = b;
      v[cyc & MASK] = b;
    end
  end

  // Reference: raw sample at strobe k is the bit driven 3 edges before that strobe.
  // Samples are taken in non-overlapping pairs; 10 gives 1, 01 gives 0, others nothing.
  task automatic model(input int a, output logic [N-1:0] w, output int done_e, output bit hf);
    int  nbits;
    int  run;
    bit  s0;
    bit  s1;
    bit  last;
    w      = '0;
    done_e = -1;
    hf     = 1'b0;
    nbits  = 0;
    run    = 0;
    last   = 1'b0;
    for (int p = 0; p < 10000; p++) begin
      for (int h = 0; h < 2; h++) begin
        int k;
        bit s;
        k = 2 * p + h + 1;
        s = v[(a + k * DIV - 3) & MASK];
`ifdef TRNG_RCT_EN
        run  = (run > 0 && s == last) ? run + 1 : 1;
        last = s;
        if (run == RCT_LIMIT) begin
          w      = '0;
          hf     = 1'b1;
          done_e = a + k * DIV;
          return;
        end
`endif
        if (h == 0) s0 = s;
        else        s1 = s;
      end
      if (s0 != s1) begin
        w     = (w << 1) | N'(s0);
        nbits = nbits + 1;
        if (nbits == N) begin
          done_e = a + (2 * p + 2) * DIV;
          return;
        end
      end
    end
  endtask

  task automatic start_planned(input int mode);
    pmode = mode;
    base  = cyc + 4;
    while (cyc < base - 1) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int e);
    e = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        e = cyc;
        break;
      end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if (req_busy !== 1'b0)    begin bad++; $display("FAIL rst_req_busy got=%b want=0", req_busy); end
    total++; if (res_valid !== 1'b0)   begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL rst_health got=%b want=0", health_fail); end
    total++; if (rnd_out !== '0)       begin bad++; $display("FAIL rst_rnd_out got=%h want=0", rnd_out); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pairs10();
    logic [N-1:0] w;
    int e, me;
    bit hf;
    start_planned(1);
    total++; if (req_busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL p10_accept busy=%b ready=%b want 1/0", req_busy, req_ready); end
    wait_res(5000, e);
    model(base, w, me, hf);
    total++; if (e !== base + 2 * N * DIV) begin bad++; $display("FAIL p10_latency got_edge=%0d want=%0d", e, base + 2 * N * DIV); end
    total++; if (e !== me) begin bad++; $display("FAIL p10_model_latency got_edge=%0d want=%0d", e, me); end
    total++; if (rnd_out !== {N{1'b1}}) begin bad++; $display("FAIL p10_word got=%h want=all ones", rnd_out); end
    total++; if (rnd_out !== w) begin bad++; $display("FAIL p10_model_word got=%h want=%h", rnd_out, w); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL p10_health got=%b want=0", health_fail); end
    total++; if (req_busy !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL p10_done_flags busy=%b ready=%b want 0/0", req_busy, req_ready); end
    consume();
  endtask

  task automatic test_mixed();
    logic [N-1:0] w;
    logic [N-1:0] exp_w;
    int e, me;
    bit hf;
    exp_w = '0;
    for (int i = 0; i < N; i++) exp_w = {exp_w[N-2:0], ((i % 3) != 0)};
    start_planned(2);
    wait_res(8000, e);
    model(base, w, me, hf);
    total++; if (rnd_out !== exp_w) begin bad++; $display("FAIL mixed_word got=%h want=%h", rnd_out, exp_w); end
    total++; if (rnd_out !== w) begin bad++; $display("FAIL mixed_model_word got=%h want=%h", rnd_out, w); end
    total++; if (e !== me) begin bad++; $display("FAIL mixed_latency got_edge=%0d want=%0d", e, me); end
    consume();
  endtask

  task automatic test_handshake();
    logic [N-1:0] w1, w2;
    int e, me, a2;
    bit hf;
    start_planned(0);
    wait_res(20000, e);
    model(base, w1, me, hf);
    total++; if (e !== me) begin bad++; $display("FAIL hs_latency got_edge=%0d want=%0d", e, me); end
    total++; if (rnd_out !== w1) begin bad++; $display("FAIL hs_word got=%h want=%h", rnd_out, w1); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      total++; if (rnd_out !== w1) begin bad++; $display("FAIL hs_hold_word cyc=%0d got=%h want=%h", i, rnd_out, w1); end
      total++; if (req_ready !== 1'b0 || res_valid !== 1'b1) begin bad++; $display("FAIL hs_hold_flags cyc=%0d ready=%b valid=%b want 0/1", i, req_ready, res_valid); end
    end
    // Request is held across the return to idle and must be taken on the first idle cycle.
    res_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    total++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL hs_release ready=%b valid=%b want 1/0", req_ready, res_valid); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a2 = cyc;
    total++; if (req_busy !== 1'b1) begin bad++; $display("FAIL hs_reaccept busy=%b want=1", req_busy); end
    wait_res(20000, e);
    model(a2, w2, me, hf);
    total++; if (e !== me) begin bad++; $display("FAIL hs2_latency got_edge=%0d want=%0d", e, me); end
    total++; if (rnd_out !== w2) begin bad++; $display("FAIL hs2_word got=%h want=%h", rnd_out, w2); end
    consume();
  endtask

  task automatic test_busy_req();
    logic [N-1:0] w;
    int e, me, a;
    bit hf;
    start_planned(0);
    a = base;
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(20, 150)) @(posedge clk);
      #1;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      total++; if (req_busy !== 1'b1) begin bad++; $display("FAIL busy_req_busy pulse=%0d got=%b want=1", p, req_busy); end
    end
    wait_res(20000, e);
    model(a, w, me, hf);
    total++; if (e !== me) begin bad++; $display("FAIL busy_req_latency got_edge=%0d want=%0d", e, me); end
    total++; if (rnd_out !== w) begin bad++; $display("FAIL busy_req_word got=%h want=%h", rnd_out, w); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] w;
    int e, me;
    bit hf;
    start_planned(1);
    while (cyc < base + 2 * 64 * DIV) begin
      @(posedge clk);
      #1;
    end
    total++; if (req_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", req_busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL rmid_ready got=%b want=1", req_ready); end
    total++; if (req_busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy got=%b want=0", req_busy); end
    total++; if (res_valid !== 1'b0)   begin bad++; $display("FAIL rmid_valid got=%b want=0", res_valid); end
    total++; if (rnd_out !== '0)       begin bad++; $display("FAIL rmid_rnd_out got=%h want=0", rnd_out); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL rmid_health got=%b want=0", health_fail); end
    start_planned(0);
    wait_res(20000, e);
    model(base, w, me, hf);
    total++; if (e !== me) begin bad++; $display("FAIL rmid_new_latency got_edge=%0d want=%0d", e, me); end
    total++; if (rnd_out !== w) begin bad++; $display("FAIL rmid_new_word got=%h want=%h", rnd_out, w); end
    consume();
  endtask

  task automatic test_stuck();
    int e;
    start_planned(3);
`ifdef TRNG_RCT_EN
    wait_res(2000, e);
    total++; if (e !== base + RCT_LIMIT * DIV) begin bad++; $display("FAIL stuck_latency got_edge=%0d want=%0d", e, base + RCT_LIMIT * DIV); end
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL stuck_health got=%b want=1", health_fail); end
    total++; if (rnd_out !== '0) begin bad++; $display("FAIL stuck_rnd_out got=%h want=0", rnd_out); end
    res_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++; if (health_fail !== 1'b0 || req_busy !== 1'b1) begin bad++; $display("FAIL stuck_clear health=%b busy=%b want 0/1", health_fail, req_busy); end
`else
    e = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (req_busy !== 1'b1 || res_valid !== 1'b0 || health_fail !== 1'b0) begin
        bad++;
        e++;
        if (e < 5) $display("FAIL stuck_hang cyc=%0d busy=%b valid=%b health=%b want 1/0/0", i, req_busy, res_valid, health_fail);
      end
    end
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pmode = 0;
  endtask

  initial begin
    test_reset();
    test_pairs10();
    test_mixed();
    test_handshake();
    test_busy_req();
    test_reset_mid();
    test_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
